uart_rx_oversampled: RTL and testbench

//  Parametrised oversampling UART receiver feeding the decode datapath; replaces the fixed 3-bit oversampling counter.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_oversampled.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and default frame constants for the oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned DefOversample  = 8;
  localparam int unsigned DefDataBits    = 8;
  localparam int unsigned DefSyncStages  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with a one-word valid/ready output buffer.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = DefOversample,
  parameter int unsigned DATA_BITS   = DefDataBits,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           rx_in,
  output logic [DATA_BITS-1:0]           data_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic                           frame_err,
  output logic                           overrun_err,
  output logic                           parity_err,
  output logic [$clog2(DATA_BITS+1)-1:0] debug_bit_cnt,
  output logic [$clog2(OVERSAMPLE)-1:0]  debug_os_cnt
);

  localparam int unsigned OsW = $clog2(OVERSAMPLE);
  localparam int unsigned BcW = $clog2(DATA_BITS + 1);
  localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [BcW-1:0] BcLast = BcW'(DATA_BITS - 1);

  logic rxs;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [OsW-1:0]       os_q, os_d;
  logic [BcW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_msb;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, overrun_err_q, parity_err_q;
  logic                 commit, frame_evt, parity_evt, overrun_evt;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // New bits enter at the MSB so that after DATA_BITS shifts bit 0 holds the first bit received.
  always_comb begin
    rx_msb = '0;
    rx_msb[DATA_BITS-1] = rxs;
  end

  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    commit     = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d = StStart;
            os_d    = '0;
          end
        end
        StStart: begin
          if (os_q == OsHalf) begin
            if (rxs) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              os_d    = '0;
              bit_d   = '0;
            end
          end else begin
            os_d = os_q + OsW'(1);
          end
        end
        StData: begin
          if (os_q == OsLast) begin
            os_d    = '0;
            shift_d = (shift_q >> 1) | rx_msb;
            bit_d   = bit_q + BcW'(1);
            if (bit_q == BcLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            os_d = os_q + OsW'(1);
          end
        end
        StParity: begin
          if (os_q == OsLast) begin
            os_d    = '0;
            state_d = StStop;
`ifdef UART_RX_PARITY_EN
            par_d   = rxs;
`endif
          end else begin
            os_d = os_q + OsW'(1);
          end
        end
        StStop: begin
          if (os_q == OsLast) begin
            os_d = '0;
            if (rxs) begin
              state_d = StIdle;
`ifdef UART_RX_PARITY_EN
              if (par_q != ^shift_q) begin
                parity_evt = 1'b1;
              end else begin
                commit = 1'b1;
              end
`else
              commit = 1'b1;
`endif
            end else begin
              frame_evt = 1'b1;
              state_d   = StBreak;
            end
          end else begin
            os_d = os_q + OsW'(1);
          end
        end
        StBreak: begin
          if (rxs) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A commit may reuse the slot being drained in the same cycle.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_evt = 1'b0;
    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
    if (commit) begin
      if (!valid_q || ready_in) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      os_q          <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      os_q          <= os_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_evt;
      overrun_err_q <= overrun_evt;
      parity_err_q  <= parity_evt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;

  logic unused_parity;
  assign unused_parity = parity_err_q ^ parity_evt;
`endif

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err     = frame_err_q;
  assign overrun_err   = overrun_err_q;
  assign debug_bit_cnt = bit_q;
  assign debug_os_cnt  = os_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled (OVERSAMPLE=8, DATA_BITS=8, SYNC_STAGES=2).
module tb_uart_rx_oversampled;

  localparam int OS = 8;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  localparam int   COMMIT_HITS = 2;
  localparam int   EXP_PE = 1;
`else
  localparam logic PAR_EN = 1'b0;
  localparam int   COMMIT_HITS = 1;
  localparam int   EXP_PE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena, rx_in, ready_in;
  logic [7:0] data_out;
  logic       valid_out, frame_err, overrun_err, parity_err;
  logic [3:0] debug_bit_cnt;
  logic [2:0] debug_os_cnt;

  int         total = 0;
  int         bad = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  uart_rx_oversampled #(
    .OVERSAMPLE (8),
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .rx_in        (rx_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .parity_err   (parity_err),
    .debug_bit_cnt(debug_bit_cnt),
    .debug_os_cnt (debug_os_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (parity_err) pe_cnt++;
    if (rst_n && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", data_out);
      end else begin
        exp_word = exp_q.pop_front();
        check("data_out", {24'h0, data_out}, {24'h0, exp_word});
      end
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // frz holds ena low for 11 cycles mid-bit; the bit still lasts OS enabled cycles.
  task automatic drive_bit(input logic b, input logic frz);
    logic [2:0] os0;
    rx_in = b;
    if (frz) begin
      repeat (4) @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      os0 = debug_os_cnt;
      repeat (10) @(negedge clk);
      check("freeze_os_cnt", {29'h0, debug_os_cnt}, {29'h0, os0});
      ena = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      repeat (OS) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int frz);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == frz);
    if (PAR_EN) drive_bit(par, 1'b0);
    drive_bit(stop, 1'b0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ready_in = r;
  endtask

  initial begin
    int hits;
    rst_n    = 1'b0;
    ena      = 1'b1;
    rx_in    = 1'b1;
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, valid_out}, 0);
    check("rst_data", {24'h0, data_out}, 0);
    check("rst_frame_err", {31'h0, frame_err}, 0);
    check("rst_overrun", {31'h0, overrun_err}, 0);
    check("rst_bit_cnt", {28'h0, debug_bit_cnt}, 0);
    check("rst_os_cnt", {29'h0, debug_os_cnt}, 0);
    rst_n = 1'b1;
    idle(5);

    // 1: clean frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5, -1);
    idle(6);
    check("t1_drained", exp_q.size(), 0);

    // 2: short low glitch must not start a frame
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(12);
    check("t2_no_frame_err", fe_cnt, 0);

    // ena freeze in the middle of data bit 3
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A, 3);
    idle(6);
    check("freeze_drained", exp_q.size(), 0);

    // 3: bad stop bit, line held low 40 clk -> exactly one frame_err
    send_frame(8'h3C, 1'b0, ^8'h3C, -1);
    repeat (32) @(negedge clk);
    idle(10);
    check("t3_frame_err_cnt", fe_cnt, 1);
    check("t3_valid_low", {31'h0, valid_out}, 0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, ^8'h01, -1);
    idle(6);
    check("t3_drained", exp_q.size(), 0);

    // 4a: overrun while buffer full
    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11, -1);
    idle(6);
    send_frame(8'h22, 1'b1, ^8'h22, -1);
    idle(6);
    check("t4_overrun_cnt", ov_cnt, 1);
    check("t4_held_valid", {31'h0, valid_out}, 1);
    check("t4_held_data", {24'h0, data_out}, 32'h11);
    set_ready(1'b1);
    idle(4);
    check("t4_drained", exp_q.size(), 0);

    // 4b: drain and reload in the commit cycle -> no overrun
    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11, -1);
    idle(6);
    exp_q.push_back(8'h22);
    hits = 0;
    fork
      send_frame(8'h22, 1'b1, ^8'h22, -1);
      begin
        for (int i = 0; i < 200 && hits < COMMIT_HITS; i++) begin
          @(negedge clk);
          if (debug_bit_cnt == 4'd8 && debug_os_cnt == 3'd6) hits++;
        end
        check("t4b_commit_seen", hits, COMMIT_HITS);
        set_ready(1'b1);
      end
    join
    idle(6);
    check("t4b_drained", exp_q.size(), 0);
    check("t4b_overrun_cnt", ov_cnt, 1);

    // 5: reset in the middle of a frame
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0 ^ (i == 1), 1'b0);
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("t5_valid", {31'h0, valid_out}, 0);
    check("t5_data", {24'h0, data_out}, 0);
    check("t5_bit_cnt", {28'h0, debug_bit_cnt}, 0);
    check("t5_os_cnt", {29'h0, debug_os_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, ^8'h81, -1);
    idle(6);
    check("t5_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch then good parity
    send_frame(8'h03, 1'b1, 1'b1, -1);
    idle(6);
    check("t6_parity_err_cnt", pe_cnt, 1);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0, -1);
    idle(6);
    check("t6_drained", exp_q.size(), 0);
`endif

    check("final_frame_err_cnt", fe_cnt, 1);
    check("final_overrun_cnt", ov_cnt, 1);
    check("final_parity_err_cnt", pe_cnt, EXP_PE);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
